// File: rtl/uart_fifo_pkg.sv
// Shared constants, types and helpers for the UART receive/transmit FIFO.
package uart_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_PTR_W = 4;
  localparam int unsigned FIFO_CNT_W = 5;
  localparam int unsigned RX_WORD_W  = 11;
  localparam int unsigned ERR_FLAG_W = 3;

  typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

  // True when slot idx lies within the cnt entries starting at rd_ptr (modulo depth).
  function automatic logic slot_occupied(input fifo_ptr_t idx, input fifo_ptr_t rd_ptr,
                                         input fifo_cnt_t cnt);
    fifo_ptr_t offs;
    offs = idx - rd_ptr;
    return (FIFO_CNT_W'(offs) < cnt);
  endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// FIFO control/status bundle between the UART core and the FIFO.
interface uart_fifo_if
  import uart_fifo_pkg::*;
#(
  parameter int unsigned width = 8
);

  logic [width-1:0] data_in;
  logic             push;
  logic             pop;
  logic             fifo_reset;
  logic             reset_status;
  logic [width-1:0] data_out;
  fifo_cnt_t        count;
  logic             overrun;
  logic             underrun;
  logic             error_bit;

  modport master (
    output data_in, push, pop, fifo_reset, reset_status,
    input  data_out, count, overrun, underrun, error_bit
  );

  modport slave (
    input  data_in, push, pop, fifo_reset, reset_status,
    output data_out, count, overrun, underrun, error_bit
  );

endinterface

// File: rtl/uart_fifo_storage.sv
// 16-entry word array: synchronous write, combinational read, per-entry clearing of
// the low status bits when an entry is retired.
module uart_fifo_storage
  import uart_fifo_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  flush,
  input  logic                  we,
  input  fifo_ptr_t             waddr,
  input  logic [width-1:0]      wdata,
  input  logic                  clr,
  input  fifo_ptr_t             caddr,
  input  fifo_ptr_t             raddr,
  output logic [width-1:0]      rdata,
  output logic [FIFO_DEPTH-1:0] flags
);

  logic [width-1:0] mem [FIFO_DEPTH];

  // Entry update; a write to the slot being retired wins over its flag clear.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (we && (waddr == FIFO_PTR_W'(i))) begin
          mem[i] <= wdata;
        end else if (clr && (caddr == FIFO_PTR_W'(i))) begin
          mem[i][ERR_FLAG_W-1:0] <= '0;
        end
      end
    end
  end

  // Combinational read port.
  assign rdata = mem[raddr];

  // Per-entry break/parity/framing indication.
  always_comb begin
    flags = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) flags[i] = |mem[i][ERR_FLAG_W-1:0];
  end

endmodule

// File: rtl/uart_fifo.sv
// UART 16-deep FIFO: pointers, occupancy count, sticky overrun/underrun and error summary.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned fifo_width = 8
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  uart_fifo_if.slave  bus
);

  fifo_ptr_t             wr_ptr;
  fifo_ptr_t             rd_ptr;
  fifo_cnt_t             count_q;
  logic                  overrun_q;
  logic                  underrun_q;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  do_pop;
  logic                  ovr_evt;
  logic                  und_evt;
  logic                  err_any;
  logic [fifo_width-1:0] rd_data;
  logic [FIFO_DEPTH-1:0] flags;

  // Qualify push/pop against occupancy; simultaneous push+pop is legal when full.
  always_comb begin
    full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    empty   = (count_q == '0);
    do_push = bus.push && (!full || bus.pop);
    do_pop  = bus.pop && !empty;
    ovr_evt = bus.push && !bus.pop && full;
    und_evt = bus.pop && !bus.push && empty;
  end

  // Pointers, count and sticky flags; a new event beats a same-cycle status clear.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (bus.fifo_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
      overrun_q  <= (overrun_q  && !bus.reset_status) || ovr_evt;
      underrun_q <= (underrun_q && !bus.reset_status) || und_evt;
    end
  end

  uart_fifo_storage #(
    .width (fifo_width)
  ) u_storage (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .flush    (bus.fifo_reset),
    .we       (do_push && !bus.fifo_reset),
    .waddr    (wr_ptr),
    .wdata    (bus.data_in),
    .clr      (do_pop && !bus.fifo_reset),
    .caddr    (rd_ptr),
    .raddr    (rd_ptr),
    .rdata    (rd_data),
    .flags    (flags)
  );

  // Error summary restricted to occupied slots.
  always_comb begin
    err_any = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (flags[i] && slot_occupied(FIFO_PTR_W'(i), rd_ptr, count_q)) err_any = 1'b1;
    end
  end

  assign bus.data_out  = rd_data;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.underrun  = underrun_q;
  assign bus.error_bit = err_any;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo at the receiver word width.
module tb_uart_fifo;
  import uart_fifo_pkg::*;

  localparam int unsigned W = RX_WORD_W;

  logic clk;
  logic wb_rst_i;

  uart_fifo_if #(.width(W)) bus ();

  uart_fifo #(.fifo_width(W)) dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         push;
    logic         pop;
    logic         frst;
    logic         rst_st;
    logic [W-1:0] din;
    logic [4:0]   cnt;
    logic [W-1:0] dout;
    logic         chk_dout;
    logic         ov;
    logic         un;
    logic         err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] exp_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ps, input logic pp, input logic fr, input logic rs,
                       input logic [W-1:0] d);
    bus.push         = ps;
    bus.pop          = pp;
    bus.fifo_reset   = fr;
    bus.reset_status = rs;
    bus.data_in      = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // push pop frst rst_st din     cnt    dout    chkd  ov    un    err
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,11'h0A8,5'd1,11'h0A8,1'b1,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,11'h155,5'd2,11'h0A8,1'b1,1'b0,1'b0,1'b1};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,11'h0FF,5'd3,11'h0A8,1'b1,1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd2,11'h155,1'b1,1'b0,1'b0,1'b1};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd1,11'h0FF,1'b1,1'b0,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd0,11'h000,1'b0,1'b0,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,11'h004,5'd1,11'h004,1'b1,1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b0,1'b0,11'h010,5'd1,11'h010,1'b1,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,11'h020,5'd2,11'h010,1'b1,1'b0,1'b0,1'b0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,11'h002,5'd3,11'h010,1'b1,1'b0,1'b0,1'b1};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd2,11'h020,1'b1,1'b0,1'b0,1'b1};
    vecs[14] = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd1,11'h002,1'b1,1'b0,1'b0,1'b1};
    vecs[15] = '{1'b0,1'b1,1'b0,1'b0,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,1'b0,11'h033,5'd1,11'h033,1'b1,1'b0,1'b0,1'b1};
    vecs[17] = '{1'b0,1'b1,1'b0,1'b1,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};
    vecs[18] = '{1'b0,1'b1,1'b0,1'b1,11'h000,5'd0,11'h000,1'b0,1'b0,1'b1,1'b0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,11'h000,5'd0,11'h000,1'b0,1'b0,1'b0,1'b0};

    // Reset state, checked while reset is held.
    wb_rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #12;
    chk("rst_count",    32'(bus.count),     32'd0);
    chk("rst_overrun",  32'(bus.overrun),   32'd0);
    chk("rst_underrun", 32'(bus.underrun),  32'd0);
    chk("rst_error",    32'(bus.error_bit), 32'd0);
    chk("rst_data_out", 32'(bus.data_out),  32'd0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    cyc();

    // Table-driven single-cycle vectors.
    for (int v = 0; v < NV; v++) begin
      drive(vecs[v].push, vecs[v].pop, vecs[v].frst, vecs[v].rst_st, vecs[v].din);
      cyc();
      chk($sformatf("v%0d_count", v),    32'(bus.count),     32'(vecs[v].cnt));
      chk($sformatf("v%0d_overrun", v),  32'(bus.overrun),   32'(vecs[v].ov));
      chk($sformatf("v%0d_underrun", v), 32'(bus.underrun),  32'(vecs[v].un));
      chk($sformatf("v%0d_error", v),    32'(bus.error_bit), 32'(vecs[v].err));
      if (vecs[v].chk_dout)
        chk($sformatf("v%0d_data_out", v), 32'(bus.data_out), 32'(vecs[v].dout));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Fill to 16, then overflow and status clear.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, W'((i + 1) * 8));
      cyc();
    end
    chk("full_count",    32'(bus.count),    32'd16);
    chk("full_data_out", 32'(bus.data_out), 32'h008);
    chk("full_overrun0", 32'(bus.overrun),  32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 11'h7F8);
    cyc();
    chk("ovf_count",   32'(bus.count),   32'd16);
    chk("ovf_overrun", 32'(bus.overrun), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc();
    chk("rstst_overrun", 32'(bus.overrun), 32'd0);
    chk("rstst_count",   32'(bus.count),   32'd16);

    // Push+pop while full: no overrun, head advances.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 11'h100);
    cyc();
    chk("pp_full_count",    32'(bus.count),    32'd16);
    chk("pp_full_overrun",  32'(bus.overrun),  32'd0);
    chk("pp_full_data_out", 32'(bus.data_out), 32'h010);

    // Overflow coinciding with status clear leaves overrun set.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 11'h7F8);
    cyc();
    chk("ovf_vs_clr_overrun", 32'(bus.overrun), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc();
    chk("clr_overrun", 32'(bus.overrun), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-stream takes effect before any clock edge.
    #1;
    wb_rst_i = 1'b1;
    #1;
    chk("async_count",    32'(bus.count),     32'd0);
    chk("async_data_out", 32'(bus.data_out),  32'd0);
    chk("async_error",    32'(bus.error_bit), 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    cyc();

    // Interleaved push/pop across two pointer wraps, checked against a queue.
    for (int i = 0; i < 40; i++) begin
      logic do_pop;
      do_pop = (i >= 4);
      if (do_pop) begin
        exp_word = q.pop_front();
        chk($sformatf("wrap%0d_data_out", i), 32'(bus.data_out), 32'(exp_word));
      end
      drive(1'b1, do_pop, 1'b0, 1'b0, W'((i * 8 + 64) % 2048));
      q.push_back(W'((i * 8 + 64) % 2048));
      cyc();
      chk($sformatf("wrap%0d_count", i), 32'(bus.count), 32'(q.size()));
    end
    while (q.size() > 0) begin
      exp_word = q.pop_front();
      chk("drain_data_out", 32'(bus.data_out), 32'(exp_word));
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
      cyc();
      chk("drain_count", 32'(bus.count), 32'(q.size()));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("end_underrun", 32'(bus.underrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter fifo_width, default 8: data word width; the receiver instantiates it with 11.
REQ-002 clk  input  1  clock; all state updates occur on its rising edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 data_in  input  fifo_width  word written on push.
REQ-005 push  input  1  write data_in this cycle.
REQ-006 pop  input  1  discard the oldest word this cycle.
REQ-007 fifo_reset  input  1  synchronous flush of contents, pointers, count and flags.
REQ-008 reset_status  input  1  synchronous clear of the overrun and underrun flags.
REQ-009 data_out  output  fifo_width  oldest stored word; combinational, no read latency.
REQ-010 count  output  5  number of stored words, 0..16.
REQ-011 overrun  output  1  sticky: a push was attempted while full.
REQ-012 underrun  output  1  sticky: a pop was attempted while empty.
REQ-013 error_bit  output  1  at least one stored word has a nonzero bit [2:0] (break, parity or framing flag).

Function
REQ-014 Depth SHALL be 16 words; read and write pointers SHALL be 4 bits and wrap from 15 to 0.
REQ-015 Push only, count<16: store data_in at the write pointer, advance the write pointer, count+1.
REQ-016 Push only, count==16: contents and count unchanged; overrun set to 1.
REQ-017 Pop only, count>0: advance the read pointer, count-1; the popped entry's bits [2:0] are cleared.
REQ-018 Pop only, count==0: no state change other than underrun set to 1.
REQ-019 Push and pop together, 0<count<=16: both performed; count unchanged; no overrun and no underrun.
REQ-020 Push and pop together, count==0: treated as push only; count becomes 1; no underrun.
REQ-021 data_out SHALL equal the entry at the read pointer; its value is don't-care when count==0.
REQ-022 error_bit SHALL be the OR of bits [2:0] over occupied entries only; it is combinational.
REQ-023 fifo_reset SHALL have priority over push and pop that cycle.
REQ-024 fifo_reset SHALL zero the pointers, count and all entries, and clear overrun and underrun.
REQ-025 reset_status SHALL clear overrun and underrun.
REQ-026 When reset_status coincides with a new overrun or underrun event, the flag SHALL end set (the new event wins).
REQ-027 Count SHALL never exceed 16 or go below 0.

Reset
REQ-028 wb_rst_i SHALL asynchronously zero the pointers, count, all entries, overrun and underrun.
REQ-029 While reset is asserted, outputs SHALL read count=0, overrun=0, underrun=0, error_bit=0 and data_out=0.

Structure
REQ-030 These constants SHALL live in the shared uart package: depth 16, pointer width 4, counter width 5, receive word width 11.
REQ-031 Word storage SHALL be one sub-module, uart_fifo_storage: a 16 x fifo_width register array with synchronous write, combinational read and per-entry clearing of bits [2:0].

Verification
REQ-032 Push 0x0A8, 0x155, 0x0FF (width 11):
  - count reads 3 and data_out=0x0A8;
  - after one pop, count=2 and data_out=0x155.
REQ-033 Fill with 16 pushes, then 1 extra push:
  - count stays 16 and overrun=1;
  - reset_status pulse -> overrun=0, count still 16.
REQ-034 Pop when empty -> underrun=1 and count=0; a following fifo_reset -> underrun=0.
REQ-035 Push 0x004 (break flag):
  - error_bit=1;
  - pop it -> error_bit=0;
  - push 0x002 behind two clean words -> error_bit=1 until that word is popped.
REQ-036 Simultaneous push/pop:
  - at count=16, count stays 16 with no overrun and data_out advances;
  - at count=0, count becomes 1 with no underrun.
REQ-037 Reset and pointer wrap:
  - assert wb_rst_i mid-stream -> count=0 immediately, without waiting for a clock edge;
  - 40 interleaved push/pop cycles -> data returned in order across pointer wrap.
